// File: rtl/risc_pkg.sv
// Shared ISA constants, sequencer state encodings and the strobe bundle type.
// Used by the sequencer, the ALU and the IR decode.
package risc_pkg;

  localparam int OP_W    = 3;
  localparam int STATE_W = 3;

  typedef enum logic [2:0] {
    HLT  = 3'd0,
    SKZ  = 3'd1,
    ADD  = 3'd2,
    ANDD = 3'd3,
    XORR = 3'd4,
    LDA  = 3'd5,
    STO  = 3'd6,
    JMP  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_e;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic load_acc;
    logic halt;
  } strb_t;

  // Opcodes that read a memory operand and load the accumulator
  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_seq_decode.sv
// Strobe decode: maps the state about to be entered, the opcode and the skip flag to its strobes.
// Latency: combinational. Backpressure: none.
module risc_seq_decode
  import risc_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] opcode,
  input  logic       skip,
  output strb_t      strb
);

  always_comb begin
    strb = '0;
    case (state)
      S0: begin
        strb.rd      = 1'b1;
        strb.load_ir = 1'b1;
      end
      S1: begin
        strb.rd      = 1'b1;
        strb.load_ir = 1'b1;
        strb.inc_pc  = 1'b1;
      end
      S3: strb.halt = (opcode == HLT);
      S4: begin
        strb.rd          = is_acc_op(opcode);
        strb.datactl_ena = (opcode == STO);
        strb.load_pc     = (opcode == JMP);
        strb.inc_pc      = (opcode == SKZ) && skip;
      end
      S5: begin
        strb.rd          = is_acc_op(opcode);
        strb.load_acc    = is_acc_op(opcode);
        strb.datactl_ena = (opcode == STO);
        strb.wr          = (opcode == STO);
        strb.inc_pc      = (opcode == SKZ) && skip;
      end
      // Bus driver held one cycle past wr so the memory sees stable data at write end
      S6: strb.datactl_ena = (opcode == STO);
      default: strb = '0;
    endcase
  end

endmodule

// File: rtl/risc_sequencer.sv
// Eight-state fetch/decode/execute controller; optional SEQ_SINGLE_STEP_EN adds a step input gating S7->S0.
// Latency: strobes are registered on the edge entering a state. Backpressure: ena=0 aborts to S0, HLT/step stall.
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               inc_pc,
  output logic               load_pc,
  output logic               load_ir,
  output logic               rd,
  output logic               wr,
  output logic               datactl_ena,
  output logic               load_acc,
  output logic               halt,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] st, st_nxt;
  logic               skip, skip_nxt;
  logic               adv;
  strb_t              strb_d, strb_q;

  always_comb begin
    adv      = 1'b1;
    st_nxt   = st;
    skip_nxt = skip;
    if (st == S3 && opcode == HLT) adv = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    if (st == S7 && !step) adv = 1'b0;
`endif
    if (adv) begin
      st_nxt = st + 3'd1;
      if (st == S3) skip_nxt = zero;
    end
  end

  // Decode looks at the next state so the registered strobes line up with the state they belong to
  risc_seq_decode u_decode (
    .state  (st_nxt),
    .opcode (opcode),
    .skip   (skip_nxt),
    .strb   (strb_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S0;
      skip   <= 1'b0;
      strb_q <= '0;
    end else if (!ena) begin
      st     <= S0;
      skip   <= 1'b0;
      strb_q <= '0;
    end else begin
      st     <= st_nxt;
      skip   <= skip_nxt;
      strb_q <= strb_d;
    end
  end

  assign inc_pc      = strb_q.inc_pc;
  assign load_pc     = strb_q.load_pc;
  assign load_ir     = strb_q.load_ir;
  assign rd          = strb_q.rd;
  assign wr          = strb_q.wr;
  assign datactl_ena = strb_q.datactl_ena;
  assign load_acc    = strb_q.load_acc;
  assign halt        = strb_q.halt;
  assign state       = st;

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: directed scenarios plus random run against a per-state strobe table model.
module tb_risc_sequencer;

  logic       clk = 1'b0;
  logic       rst, ena, zero, step;
  logic [2:0] opcode;
  logic       inc_pc, load_pc, load_ir, rd, wr, datactl_ena, load_acc, halt;
  logic [2:0] state;
  logic [7:0] dut_out;

  int   errors = 0;
  int   checks = 0;
  int   ms     = 0;
  bit   mskip  = 1'b0;
  logic [7:0] mout = 8'h00;
  bit   step_mode;

  always #5 clk = ~clk;

  risc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
`ifdef SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_ir     (load_ir),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .load_acc    (load_acc),
    .halt        (halt),
    .state       (state)
  );

  assign dut_out = {inc_pc, load_pc, load_ir, rd, wr, datactl_ena, load_acc, halt};

  // Strobe table: which strobes each instruction expects while sitting in state s
  function automatic logic [7:0] expect_out(input int s, input int op, input bit sk);
    bit acc  = (op >= 2) && (op <= 5);
    bit sto  = (op == 6);
    bit exe  = (s == 4) || (s == 5);
    bit inc  = (s == 1) || ((op == 1) && sk && exe);
    bit ldpc = (op == 7) && (s == 4);
    bit ldir = (s <= 1);
    bit rdv  = (s <= 1) || (acc && exe);
    bit wrv  = sto && (s == 5);
    bit dc   = sto && (s >= 4) && (s <= 6);
    bit la   = acc && (s == 5);
    bit h    = (op == 0) && (s == 3);
    return {inc, ldpc, ldir, rdv, wrv, dc, la, h};
  endfunction

  // One clock: update the model from the inputs seen at the edge, then settle
  task automatic tick();
    bit adv;
    @(posedge clk);
    if (!ena) begin
      ms = 0; mskip = 1'b0; mout = 8'h00;
    end else begin
      adv = !(ms == 3 && int'(opcode) == 0) && !(step_mode && ms == 7 && !step);
      if (adv) begin
        if (ms == 3) mskip = zero;
        ms = (ms + 1) % 8;
      end
      mout = expect_out(ms, int'(opcode), mskip);
    end
    #1;
  endtask

  task automatic park();
    ena = 1'b0;
    tick();
    ena = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ms = 0; mskip = 1'b0; mout = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (dut_out !== 8'h00) begin errors++; $display("FAIL reset_outs got=%b exp=00000000", dut_out); end
    // Reset asserted in the middle of S5 of an ADD
    ena = 1'b1; opcode = 3'd2; zero = 1'b0;
    repeat (5) tick();
    checks++;
    if (state !== 3'd5 || dut_out !== mout) begin
      errors++; $display("FAIL add_s5 got st=%0d out=%b exp st=5 out=%b", state, dut_out, mout);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || dut_out !== 8'h00) begin
      errors++; $display("FAIL async_reset got st=%0d out=%b exp st=0 out=00000000", state, dut_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    ms = 0; mskip = 1'b0; mout = 8'h00;
    tick();
    checks++;
    if (state !== 3'd1 || dut_out !== 8'b10110000) begin
      errors++; $display("FAIL fetch_after_reset got st=%0d out=%b exp st=1 out=10110000", state, dut_out);
    end
  endtask

  task automatic test_lda();
    int n_la = 0, n_rd = 0, n_inc = 0;
    park();
    opcode = 3'd5;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (state !== 3'(ms) || dut_out !== mout) begin
        errors++; $display("FAIL lda_cycle got st=%0d out=%b exp st=%0d out=%b", state, dut_out, ms, mout);
      end
      n_la += int'(load_acc); n_rd += int'(rd); n_inc += int'(inc_pc);
    end
    checks++;
    if (n_la != 1 || n_rd != 4 || n_inc != 1) begin
      errors++; $display("FAIL lda_counts got la=%0d rd=%0d inc=%0d exp 1 4 1", n_la, n_rd, n_inc);
    end
  endtask

  task automatic test_sto();
    int n_dc = 0, n_wr = 0, n_rd_exec = 0;
    park();
    opcode = 3'd6;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (state !== 3'(ms) || dut_out !== mout) begin
        errors++; $display("FAIL sto_cycle got st=%0d out=%b exp st=%0d out=%b", state, dut_out, ms, mout);
      end
      n_dc += int'(datactl_ena); n_wr += int'(wr);
      if (state >= 3'd4) n_rd_exec += int'(rd);
    end
    checks++;
    if (n_dc != 3 || n_wr != 1 || n_rd_exec != 0) begin
      errors++; $display("FAIL sto_counts got dc=%0d wr=%0d rd47=%0d exp 3 1 0", n_dc, n_wr, n_rd_exec);
    end
  endtask

  task automatic test_skz();
    int n_inc;
    opcode = 3'd1;
    for (int pass = 0; pass < 3; pass++) begin
      park();
      n_inc = 0;
      for (int i = 0; i < 8; i++) begin
        // pass 2: zero high only up to the S3->S4 edge, low during S4
        zero = (pass == 0) ? 1'b1 : (pass == 1) ? 1'b0 : (ms <= 3);
        tick();
        checks++;
        if (state !== 3'(ms) || dut_out !== mout) begin
          errors++; $display("FAIL skz_cycle p=%0d got st=%0d out=%b exp st=%0d out=%b",
                             pass, state, dut_out, ms, mout);
        end
        n_inc += int'(inc_pc);
      end
      checks++;
      if (n_inc != ((pass == 1) ? 1 : 3)) begin
        errors++; $display("FAIL skz_inc p=%0d got=%0d exp=%0d", pass, n_inc, (pass == 1) ? 1 : 3);
      end
    end
  endtask

  task automatic test_hlt();
    int stuck = 0;
    park();
    opcode = 3'd0;
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state == 3'd3 && halt) stuck++;
    end
    checks++;
    if (stuck != 20 || dut_out !== mout) begin
      errors++; $display("FAIL hlt_hold got held=%0d out=%b exp held=20 out=%b", stuck, dut_out, mout);
    end
    ena = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || halt !== 1'b0) begin
      errors++; $display("FAIL hlt_release got st=%0d halt=%b exp st=0 halt=0", state, halt);
    end
    ena = 1'b1;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_step();
    int n_s0 = 0;
    step = 1'b0;
    opcode = 3'd2;
    park();
    repeat (12) tick();
    checks++;
    if (state !== 3'd7 || dut_out !== 8'h00) begin
      errors++; $display("FAIL step_park got st=%0d out=%b exp st=7 out=00000000", state, dut_out);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    if (state == 3'd0) n_s0++;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (state !== 3'(ms) || dut_out !== mout) begin
        errors++; $display("FAIL step_cycle got st=%0d out=%b exp st=%0d out=%b", state, dut_out, ms, mout);
      end
      if (state == 3'd0) n_s0++;
    end
    checks++;
    if (n_s0 != 1 || state !== 3'd7) begin
      errors++; $display("FAIL step_once got s0_visits=%0d st=%0d exp 1 7", n_s0, state);
    end
    step = 1'b1;
  endtask
`endif

  task automatic test_random();
    park();
    for (int i = 0; i < 1500; i++) begin
      ena  = ($urandom_range(0, 39) != 0);
      zero = $urandom_range(0, 1) != 0;
      if (ms == 1) opcode = 3'($urandom_range(0, 7));
      if (step_mode) step = ($urandom_range(0, 9) < 7);
      tick();
      checks++;
      if (state !== 3'(ms) || dut_out !== mout) begin
        errors++; $display("FAIL random_cycle i=%0d got st=%0d out=%b exp st=%0d out=%b",
                           i, state, dut_out, ms, mout);
      end
      checks++;
      if (rd && wr) begin errors++; $display("FAIL rd_wr_overlap i=%0d got rd=1 wr=1 exp exclusive", i); end
    end
    step = 1'b1;
  endtask

  initial begin
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b1;
`else
    step_mode = 1'b0;
`endif
    rst = 1'b1; ena = 1'b0; zero = 1'b0; step = 1'b1; opcode = 3'd0;
    #2;
    test_reset();
    test_lda();
    test_sto();
    test_skz();
    test_hlt();
`ifdef SEQ_SINGLE_STEP_EN
    test_step();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
